// File: rtl/rr_mux_stage.sv
// rr_mux_stage: N-input registered output multiplexer with valid/ready
// handshaking. Channel choice is either a fixed select index (mode 0) or
// round-robin arbitration (mode 1). The output is a one-deep register that
// can be drained and reloaded on the same edge, so a steady stream runs at
// one word per cycle.
module rr_mux_stage #(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mode,
    input  logic [SEL_WIDTH-1:0]        select,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN*BIT_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_valid,
    output logic [BIT_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]        out_sel,
    input  logic                        out_ready
);

    logic [BIT_WIDTH-1:0] ch_data [NUM_IN];

    logic                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_WIDTH-1:0] out_sel_q,   out_sel_d;
    logic [SEL_WIDTH-1:0] ptr_q,       ptr_d;

    logic                 grant_vld;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic [SEL_WIDTH-1:0] scan_idx;
    logic                 load_en;

    // The output register can take a new word when it is empty or is
    // being consumed on this very edge.
    assign load_en = !out_valid_q || out_ready;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign ch_data[gi]  = in_data[gi*BIT_WIDTH +: BIT_WIDTH];
            // Ready only for the single granted channel, and never while in reset.
            assign in_ready[gi] = !reset && load_en && grant_vld
                                  && (grant_idx == SEL_WIDTH'(gi));
        end
    endgenerate

    // Grant selection: fixed index in mode 0, round-robin scan after ptr in mode 1.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (!mode) begin
            // Indices at or above NUM_IN never match any channel, so they never grant.
            for (int i = 0; i < NUM_IN; i++) begin
                if (select == SEL_WIDTH'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_WIDTH'(i);
                end
            end
        end else begin
            // Walk the scan order backwards so the earliest candidate after
            // ptr is the last assignment and therefore wins. The wrap is
            // modulo NUM_IN, not the power of two of the index width.
            for (int k = NUM_IN; k >= 1; k--) begin
                scan_idx = SEL_WIDTH'((int'(ptr_q) + k) % NUM_IN);
                if (in_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = ch_data[grant_idx];
                out_sel_d  = grant_idx;
                if (mode) begin
                    ptr_d = grant_idx;
                end
            end
        end
    end

    // State registers; ptr resets to the last channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= SEL_WIDTH'(NUM_IN - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Bench for rr_mux_stage with five channels (non-power-of-two, so both the
// modulo-NUM_IN wrap and out-of-range select values are exercised).
// Directed vectors from a table, hand-written multi-cycle sequences, and
// randomized traffic against a reference model.
module tb_rr_mux_stage;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int SW = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             mode;
    logic [SW-1:0]    select;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_sel;
    logic             out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] chd [N];

    rr_mux_stage #(.BIT_WIDTH(W), .NUM_IN(N), .SEL_WIDTH(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .select    (select),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rst;
        bit           m;
        logic [2:0]   sel;
        logic [4:0]   vld;
        bit           ordy;
        logic [4:0]   rdy;
        bit           ov;
        logic [2:0]   os;
        logic [31:0]  od;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic apply(input bit rst, input bit m, input logic [2:0] sel,
                         input logic [4:0] vld, input bit ordy);
        reset     = rst;
        mode      = m;
        select    = sel;
        in_valid  = vld;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = chd[i];
    endtask

    // One cycle: drive, check in_ready before the edge, check registers after it.
    task automatic do_cycle(input string name, input bit rst, input bit m, input logic [2:0] sel,
                            input logic [4:0] vld, input bit ordy, input logic [4:0] e_rdy,
                            input bit e_ov, input logic [2:0] e_os, input logic [31:0] e_od);
        apply(rst, m, sel, vld, ordy);
        #1;
        check({name, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        check({name, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        check({name, ".out_sel"},   32'(out_sel),   32'(e_os));
        check({name, ".out_data"},  out_data,       e_od);
        $display("%s: rst=%0d mode=%0d sel=%0d vld=%b ordy=%0d -> rdy=%b ov=%0d os=%0d od=%h",
                 name, rst, m, sel, vld, ordy, in_ready, out_valid, out_sel, out_data);
    endtask

    // Reference grant from the arbitration rules; -1 means no grant.
    function automatic int model_grant(bit m, int sel, logic [N-1:0] v, int p);
        if (!m) begin
            if (sel < N) begin
                if (v[sel]) return sel;
            end
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin
        bit           m_valid;
        logic [W-1:0] m_data;
        int           m_sel;
        int           m_ptr;

        chd[0] = 32'h10; chd[1] = 32'h11; chd[2] = 32'hDEADBEEF; chd[3] = 32'h13; chd[4] = 32'h14;
        apply(1'b1, 1'b0, 3'd0, 5'b0, 1'b0);

        //            rst m  sel   vld       ordy rdy       ov os    od
        tbl[0]  = '{1, 0, 3'd0, 5'b00000, 1, 5'b00000, 0, 3'd0, 32'h0};
        tbl[1]  = '{1, 0, 3'd0, 5'b11111, 1, 5'b00000, 0, 3'd0, 32'h0};
        tbl[2]  = '{0, 0, 3'd2, 5'b11111, 1, 5'b00100, 1, 3'd2, 32'hDEADBEEF};
        tbl[3]  = '{0, 0, 3'd5, 5'b11111, 1, 5'b00000, 0, 3'd2, 32'hDEADBEEF};
        tbl[4]  = '{0, 0, 3'd7, 5'b11111, 1, 5'b00000, 0, 3'd2, 32'hDEADBEEF};
        tbl[5]  = '{0, 0, 3'd4, 5'b11111, 1, 5'b10000, 1, 3'd4, 32'h14};
        tbl[6]  = '{0, 0, 3'd1, 5'b11101, 1, 5'b00000, 0, 3'd4, 32'h14};
        tbl[7]  = '{0, 1, 3'd0, 5'b11111, 1, 5'b00001, 1, 3'd0, 32'h10};
        tbl[8]  = '{0, 1, 3'd0, 5'b11111, 1, 5'b00010, 1, 3'd1, 32'h11};
        tbl[9]  = '{0, 1, 3'd0, 5'b11111, 1, 5'b00100, 1, 3'd2, 32'hDEADBEEF};
        tbl[10] = '{0, 1, 3'd0, 5'b11111, 1, 5'b01000, 1, 3'd3, 32'h13};
        tbl[11] = '{0, 1, 3'd0, 5'b11111, 1, 5'b10000, 1, 3'd4, 32'h14};
        tbl[12] = '{0, 1, 3'd0, 5'b11111, 1, 5'b00001, 1, 3'd0, 32'h10};
        tbl[13] = '{0, 1, 3'd0, 5'b10001, 1, 5'b10000, 1, 3'd4, 32'h14};
        tbl[14] = '{0, 1, 3'd0, 5'b10001, 1, 5'b00001, 1, 3'd0, 32'h10};
        tbl[15] = '{0, 1, 3'd0, 5'b10001, 1, 5'b10000, 1, 3'd4, 32'h14};
        tbl[16] = '{0, 1, 3'd0, 5'b10001, 0, 5'b00000, 1, 3'd4, 32'h14};
        tbl[17] = '{0, 0, 3'd0, 5'b10001, 0, 5'b00000, 1, 3'd4, 32'h14};
        tbl[18] = '{0, 0, 3'd0, 5'b10001, 1, 5'b00001, 1, 3'd0, 32'h10};
        tbl[19] = '{0, 1, 3'd0, 5'b11111, 1, 5'b00001, 1, 3'd0, 32'h10};
        tbl[20] = '{0, 1, 3'd0, 5'b00000, 1, 5'b00000, 0, 3'd0, 32'h10};

        @(posedge clk);
        #1;
        for (int t = 0; t < 21; t++) begin
            do_cycle($sformatf("tbl%0d", t), tbl[t].rst, tbl[t].m, tbl[t].sel, tbl[t].vld,
                     tbl[t].ordy, tbl[t].rdy, tbl[t].ov, tbl[t].os, tbl[t].od);
        end

        // Backpressure: 0xA5 held through three stalled cycles, then replaced with no bubble.
        chd[1] = 32'hA5;
        do_cycle("bp_load", 0, 0, 3'd1, 5'b11111, 1, 5'b00010, 1, 3'd1, 32'hA5);
        chd[1] = 32'h5A; chd[3] = 32'h33;
        for (int s = 0; s < 3; s++) begin
            do_cycle($sformatf("bp_stall%0d", s), 0, 0, 3'd3, 5'b11111, 0, 5'b00000, 1, 3'd1, 32'hA5);
        end
        do_cycle("bp_release", 0, 0, 3'd3, 5'b11111, 1, 5'b01000, 1, 3'd3, 32'h33);

        // Reset mid-stall: advance ptr to 2, stall, reset; first mode-1 grant is channel 0 again.
        do_cycle("rs_rr1", 0, 1, 3'd0, 5'b11111, 1, 5'b00010, 1, 3'd1, 32'h5A);
        do_cycle("rs_rr2", 0, 1, 3'd0, 5'b11111, 1, 5'b00100, 1, 3'd2, 32'hDEADBEEF);
        do_cycle("rs_stall", 0, 1, 3'd0, 5'b11111, 0, 5'b00000, 1, 3'd2, 32'hDEADBEEF);
        do_cycle("rs_reset", 1, 1, 3'd0, 5'b11111, 0, 5'b00000, 0, 3'd0, 32'h0);
        do_cycle("rs_first", 0, 1, 3'd0, 5'b11111, 1, 5'b00001, 1, 3'd0, 32'h10);

        // Randomized traffic against the reference model; first cycle is a reset.
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = N - 1;
        for (int c = 0; c < 1500; c++) begin
            bit           r_rst, r_m, r_ordy;
            int           r_sel, g;
            logic [N-1:0] r_vld, e_rdy;
            bit           load;

            r_rst  = (c == 0) || ($urandom_range(0, 63) == 0);
            r_m    = 1'($urandom_range(0, 1));
            r_sel  = $urandom_range(0, 7);
            r_vld  = N'($urandom);
            r_ordy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) chd[i] = $urandom;
            apply(r_rst, r_m, 3'(r_sel), r_vld, r_ordy);

            g     = model_grant(r_m, r_sel, r_vld, m_ptr);
            load  = !m_valid || r_ordy;
            e_rdy = (!r_rst && load && g >= 0) ? N'(1 << g) : '0;
            #1;
            check($sformatf("rnd%0d.in_ready", c), 32'(in_ready), 32'(e_rdy));

            if (r_rst) begin
                m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = N - 1;
            end else if (load) begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_data = chd[g];
                    m_sel  = g;
                    if (r_m) m_ptr = g;
                end
            end

            @(posedge clk);
            #1;
            check($sformatf("rnd%0d.out_valid", c), 32'(out_valid), 32'(m_valid));
            check($sformatf("rnd%0d.out_sel", c),   32'(out_sel),   32'(m_sel));
            check($sformatf("rnd%0d.out_data", c),  out_data,       m_data);
            if (!r_rst && g >= 0 && load) begin
                $display("rnd%0d: mode=%0d transfer ch%0d data=%h", c, r_m, g, m_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
